// File: rtl/cam_arbiter.sv
// cam_arbiter: round-robin arbiter sharing one CAM read/write port among
// num_req_p requesters. One-deep issue register toward the CAM and a
// one-entry tag pipe that routes each read result back to its requester.
module cam_arbiter #(
  parameter int num_req_p   = 4,
  parameter int key_width_p = 16,
  parameter int val_width_p = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [num_req_p-1:0]             req_valid_i,
  input  logic [num_req_p-1:0]             req_rw_n_i,
  input  logic [num_req_p*key_width_p-1:0] req_key_i,
  input  logic [num_req_p*val_width_p-1:0] req_val_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic [num_req_p-1:0]             resp_valid_o,
  output logic                             resp_hit_o,
  output logic [val_width_p-1:0]           resp_val_o,
  output logic                             cam_valid_o,
  output logic                             cam_rw_n_o,
  output logic [key_width_p-1:0]           cam_key_o,
  output logic [val_width_p-1:0]           cam_val_o,
  input  logic                             cam_hit_i,
  input  logic [val_width_p-1:0]           cam_val_i
);

  localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [ptr_w_lp-1:0]    ptr_q, ptr_d;
  logic                   issue_valid_q, issue_valid_d;
  logic                   issue_rw_n_q, issue_rw_n_d;
  logic [key_width_p-1:0] issue_key_q, issue_key_d;
  logic [val_width_p-1:0] issue_val_q, issue_val_d;
  logic [ptr_w_lp-1:0]    issue_id_q, issue_id_d;
  logic                   tag_valid_q, tag_valid_d;
  logic [ptr_w_lp-1:0]    tag_id_q, tag_id_d;

  logic [num_req_p-1:0]   grant_oh;
  logic                   grant_found;
  logic [ptr_w_lp-1:0]    grant_id;
  logic [ptr_w_lp-1:0]    cand;

  // Pick the first valid requester starting at ptr and wrapping around.
  always_comb begin
    grant_oh    = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < num_req_p; k++) begin
      cand = ptr_w_lp'((int'(ptr_q) + k) % num_req_p);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found    = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_id       = cand;
      end
    end
  end

  assign req_ready_o = grant_oh;

  // Next pointer, issue register and read tag.
  always_comb begin
    ptr_d         = ptr_q;
    issue_valid_d = 1'b0;
    issue_rw_n_d  = issue_rw_n_q;
    issue_key_d   = issue_key_q;
    issue_val_d   = issue_val_q;
    issue_id_d    = issue_id_q;
    tag_valid_d   = issue_valid_q & issue_rw_n_q;
    tag_id_d      = issue_valid_q ? issue_id_q : tag_id_q;

    if (grant_found) begin
      ptr_d         = (grant_id == ptr_w_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
      issue_valid_d = 1'b1;
      issue_rw_n_d  = req_rw_n_i[grant_id];
      issue_key_d   = req_key_i[int'(grant_id)*key_width_p +: key_width_p];
      issue_val_d   = req_val_i[int'(grant_id)*val_width_p +: val_width_p];
      issue_id_d    = grant_id;
    end
  end

  // State registers; reset drops any in-flight command and pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_rw_n_q  <= 1'b1;
      issue_key_q   <= '0;
      issue_val_q   <= '0;
      issue_id_q    <= '0;
      tag_valid_q   <= 1'b0;
      tag_id_q      <= '0;
    end else begin
      ptr_q         <= ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_rw_n_q  <= issue_rw_n_d;
      issue_key_q   <= issue_key_d;
      issue_val_q   <= issue_val_d;
      issue_id_q    <= issue_id_d;
      tag_valid_q   <= tag_valid_d;
      tag_id_q      <= tag_id_d;
    end
  end

  assign cam_valid_o = issue_valid_q;
  assign cam_rw_n_o  = issue_rw_n_q;
  assign cam_key_o   = issue_key_q;
  assign cam_val_o   = issue_val_q;

  // Steer the CAM read result to the requester recorded in the tag.
  always_comb begin
    resp_valid_o = '0;
    if (tag_valid_q) resp_valid_o[tag_id_q] = 1'b1;
  end

  assign resp_hit_o = cam_hit_i;
  assign resp_val_o = cam_val_i;

endmodule
